btb_set_assoc: RTL and testbench

Set-associative, dual-lookup branch target buffer for the fetch stage; successor to the direct-mapped BTB. Ways, sets and XLEN are parameters. Features:
- Two-stage update pipeline with same-set forwarding.
- Deterministic victim selection: first invalid way, else round-robin.
- Single-entry invalidate.
- Full flush, implemented as a set-by-set sweep state machine. The same sweep also runs after reset, because tag, target and valid bits live in RAM.

---
 rtl/btb_set_assoc.sv | 252 +++++++++++++++++++++++++
 tb/tb_btb_set_assoc.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/btb_set_assoc.sv
// Set-associative dual-lookup branch target buffer with a two-stage update pipeline
// and a set-by-set sweep that clears the valid RAM after reset and on flush.
//
// state   | meaning
// S_SWEEP | clearing one set per edge; lookups miss, requests dropped
// S_IDLE  | normal lookup / update / invalidate operation
module btb_set_assoc #(
  parameter int XLEN      = 32,
  parameter int SETS_LOG2 = 6,
  parameter int WAYS      = 4,
  parameter int TAG_SIZE  = XLEN - SETS_LOG2 - 2
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic [XLEN-1:0] pc1,
  input  logic [XLEN-1:0] pc2,
  output logic            btb_hit1,
  output logic            btb_hit2,
  output logic [XLEN-1:0] pred_target1,
  output logic [XLEN-1:0] pred_target2,
  output logic            is_ret1,
  output logic            is_ret2,
  output logic            is_branch1,
  output logic            is_branch2,
  input  logic            update_btb,
  input  logic            invalidate_btb,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] actual_target_address,
  input  logic            ex_is_ret,
  input  logic            ex_is_branch,
  input  logic            flush_btb,
  output logic            btb_busy
);
  localparam int SETS = 1 << SETS_LOG2;
  localparam int WL   = $clog2(WAYS);

  typedef enum logic {S_SWEEP, S_IDLE} state_t;

  state_t                 r_state, w_state_nxt;
  logic [SETS_LOG2-1:0]   r_sweep_idx, w_sweep_nxt;

  logic [TAG_SIZE-1:0]    r_tag   [WAYS][SETS];
  logic [XLEN-1:0]        r_tgt   [WAYS][SETS];
  logic                   r_valid [WAYS][SETS];
  logic                   r_ret   [WAYS][SETS];
  logic                   r_br    [WAYS][SETS];
  logic [WL-1:0]          r_rr    [SETS];

  logic                   w_idle, w_flush;
  logic                   w_unused_bits;

  assign w_idle   = (r_state == S_IDLE);
  assign w_flush  = w_idle && flush_btb;
  assign btb_busy = (r_state == S_SWEEP);
  assign w_unused_bits = &{1'b0, pc1[1:0], pc2[1:0], ex_pc[1:0]};

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_SWEEP;
      r_sweep_idx <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sweep_idx <= w_sweep_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep_idx;
    case (r_state)
      S_SWEEP: begin
        w_sweep_nxt = r_sweep_idx + 1'b1;
        if (&r_sweep_idx) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (flush_btb) begin
          w_state_nxt = S_SWEEP;
          w_sweep_nxt = '0;
        end
      end
      default: w_state_nxt = S_SWEEP;
    endcase
  end

  // Lookup: read the RAM combinationally and register the result, so an edge
  // that also writes the array returns the pre-write contents.
  logic [SETS_LOG2-1:0] w_lidx [2];
  logic [TAG_SIZE-1:0]  w_ltag [2];
  logic [1:0]           w_lhit, w_lret, w_lbr;
  logic [XLEN-1:0]      w_ltgt [2];

  assign w_lidx[0] = pc1[SETS_LOG2+1:2];
  assign w_lidx[1] = pc2[SETS_LOG2+1:2];
  assign w_ltag[0] = pc1[XLEN-1:SETS_LOG2+2];
  assign w_ltag[1] = pc2[XLEN-1:SETS_LOG2+2];

  always_comb begin
    w_lhit = '0;
    w_lret = '0;
    w_lbr  = '0;
    for (int p = 0; p < 2; p++) begin
      w_ltgt[p] = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (r_valid[w][w_lidx[p]] && (r_tag[w][w_lidx[p]] == w_ltag[p])) begin
          w_lhit[p] = 1'b1;
          w_ltgt[p] = w_ltgt[p] | r_tgt[w][w_lidx[p]];
          w_lret[p] = w_lret[p] | r_ret[w][w_lidx[p]];
          w_lbr[p]  = w_lbr[p]  | r_br[w][w_lidx[p]];
        end
      end
    end
  end

  logic            r_hit1, r_hit2, r_ret1, r_ret2, r_br1, r_br2;
  logic [XLEN-1:0] r_ptgt1, r_ptgt2;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_hit1  <= 1'b0;
      r_hit2  <= 1'b0;
      r_ret1  <= 1'b0;
      r_ret2  <= 1'b0;
      r_br1   <= 1'b0;
      r_br2   <= 1'b0;
      r_ptgt1 <= '0;
      r_ptgt2 <= '0;
    end else begin
      r_hit1  <= w_idle && w_lhit[0];
      r_hit2  <= w_idle && w_lhit[1];
      r_ret1  <= w_idle && w_lret[0];
      r_ret2  <= w_idle && w_lret[1];
      r_br1   <= w_idle && w_lbr[0];
      r_br2   <= w_idle && w_lbr[1];
      r_ptgt1 <= w_idle ? w_ltgt[0] : '0;
      r_ptgt2 <= w_idle ? w_ltgt[1] : '0;
    end
  end

  assign btb_hit1     = r_hit1;
  assign btb_hit2     = r_hit2;
  assign is_ret1      = r_ret1;
  assign is_ret2      = r_ret2;
  assign is_branch1   = r_br1;
  assign is_branch2   = r_br2;
  assign pred_target1 = r_ptgt1;
  assign pred_target2 = r_ptgt2;

  // U2 stage registers (captured at U1)
  logic                 r_u2_vld, r_u2_inv, r_u2_ret, r_u2_br;
  logic [SETS_LOG2-1:0] r_u2_idx;
  logic [TAG_SIZE-1:0]  r_u2_tag;
  logic [XLEN-1:0]      r_u2_tgt;
  logic [TAG_SIZE-1:0]  r_u2_tags [WAYS];
  logic [WAYS-1:0]      r_u2_valids;
  logic [WL-1:0]        r_u2_rr;

  logic                 w_match_any, w_free_any, w_u2_we, w_rr_bump;
  logic [WL-1:0]        w_match_way, w_free_way, w_sel, w_rr_new;

  always_comb begin
    w_match_any = 1'b0;
    w_match_way = '0;
    w_free_any  = 1'b0;
    w_free_way  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_u2_valids[w] && (r_u2_tags[w] == r_u2_tag)) begin
        w_match_any = 1'b1;
        w_match_way = WL'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_u2_valids[w]) begin
        w_free_any = 1'b1;
        w_free_way = WL'(w);
      end
    end
  end

  assign w_sel     = w_match_any ? w_match_way : (w_free_any ? w_free_way : r_u2_rr);
  assign w_u2_we   = r_u2_vld && !w_flush && (!r_u2_inv || w_match_any);
  assign w_rr_bump = w_u2_we && !r_u2_inv && !w_match_any && !w_free_any;
  assign w_rr_new  = r_u2_rr + 1'b1;

  always_ff @(posedge CLK) begin
    if (r_state == S_SWEEP) begin
      for (int w = 0; w < WAYS; w++) r_valid[w][r_sweep_idx] <= 1'b0;
    end else if (w_u2_we) begin
      r_valid[w_sel][r_u2_idx] <= !r_u2_inv;
      if (!r_u2_inv) begin
        r_tag[w_sel][r_u2_idx] <= r_u2_tag;
        r_tgt[w_sel][r_u2_idx] <= r_u2_tgt;
        r_ret[w_sel][r_u2_idx] <= r_u2_ret;
        r_br[w_sel][r_u2_idx]  <= r_u2_br;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else if (r_state == S_SWEEP) begin
      r_rr[r_sweep_idx] <= '0;
    end else if (w_rr_bump) begin
      r_rr[r_u2_idx] <= w_rr_new;
    end
  end

  // U1: capture the request and the set's tags/valids, substituting the
  // values U2 is writing this edge when both stages address the same set.
  logic                 w_u1_req, w_fwd;
  logic [SETS_LOG2-1:0] w_u1_idx;

  assign w_u1_idx = ex_pc[SETS_LOG2+1:2];
  assign w_u1_req = w_idle && !flush_btb && (update_btb || invalidate_btb);
  assign w_fwd    = w_u2_we && (r_u2_idx == w_u1_idx);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_u2_vld    <= 1'b0;
      r_u2_inv    <= 1'b0;
      r_u2_ret    <= 1'b0;
      r_u2_br     <= 1'b0;
      r_u2_idx    <= '0;
      r_u2_tag    <= '0;
      r_u2_tgt    <= '0;
      r_u2_valids <= '0;
      r_u2_rr     <= '0;
      for (int w = 0; w < WAYS; w++) r_u2_tags[w] <= '0;
    end else begin
      r_u2_vld <= w_u1_req;
      if (w_u1_req) begin
        r_u2_inv <= invalidate_btb;
        r_u2_ret <= ex_is_ret;
        r_u2_br  <= ex_is_branch;
        r_u2_idx <= w_u1_idx;
        r_u2_tag <= ex_pc[XLEN-1:SETS_LOG2+2];
        r_u2_tgt <= actual_target_address;
        r_u2_rr  <= (w_fwd && w_rr_bump) ? w_rr_new : r_rr[w_u1_idx];
        for (int w = 0; w < WAYS; w++) begin
          if (w_fwd && (w_sel == WL'(w))) begin
            r_u2_valids[w] <= !r_u2_inv;
            r_u2_tags[w]   <= r_u2_inv ? r_tag[w][w_u1_idx] : r_u2_tag;
          end else begin
            r_u2_valids[w] <= r_valid[w][w_u1_idx];
            r_u2_tags[w]   <= r_tag[w][w_u1_idx];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed bench for btb_set_assoc: sweep timing, lookup/update latency,
// victim choice, forwarding, invalidate, flush and reset-restart.
module tb_btb_set_assoc;
  logic        CLK = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pc1 = '0, pc2 = '0, ex_pc = '0, actual_target_address = '0;
  logic        update_btb = 1'b0, invalidate_btb = 1'b0, flush_btb = 1'b0;
  logic        ex_is_ret = 1'b0, ex_is_branch = 1'b0;
  logic        btb_hit1, btb_hit2, is_ret1, is_ret2, is_branch1, is_branch2, btb_busy;
  logic [31:0] pred_target1, pred_target2;

  int n_cmp = 0;
  int n_fail = 0;
  int n;
  logic sweep_hit;

  btb_set_assoc dut (
    .CLK(CLK), .reset_n(reset_n), .pc1(pc1), .pc2(pc2),
    .btb_hit1(btb_hit1), .btb_hit2(btb_hit2),
    .pred_target1(pred_target1), .pred_target2(pred_target2),
    .is_ret1(is_ret1), .is_ret2(is_ret2), .is_branch1(is_branch1), .is_branch2(is_branch2),
    .update_btb(update_btb), .invalidate_btb(invalidate_btb), .ex_pc(ex_pc),
    .actual_target_address(actual_target_address), .ex_is_ret(ex_is_ret),
    .ex_is_branch(ex_is_branch), .flush_btb(flush_btb), .btb_busy(btb_busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] a, input logic [31:0] t, input logic r, input logic b);
    update_btb = 1'b1;
    ex_pc = a;
    actual_target_address = t;
    ex_is_ret = r;
    ex_is_branch = b;
    tick();
    update_btb = 1'b0;
  endtask

  task automatic inv(input logic [31:0] a);
    invalidate_btb = 1'b1;
    ex_pc = a;
    tick();
    invalidate_btb = 1'b0;
  endtask

  task automatic look(input logic [31:0] a1, input logic [31:0] a2);
    pc1 = a1;
    pc2 = a2;
    tick();
  endtask

  task automatic sweep_len(output int cnt);
    cnt = 0;
    while (btb_busy && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    tick();
    chk("rst_busy", 32'(btb_busy), 1);
    chk("rst_hit1", 32'(btb_hit1), 0);
    chk("rst_tgt1", pred_target1, 0);
    chk("rst_hit2", 32'(btb_hit2), 0);
    tick();
    reset_n = 1'b1;

    // sweep after reset; an update and lookup presented throughout must be ignored
    pc1 = 32'h1000;
    upd_hold: begin
      update_btb = 1'b1;
      ex_pc = 32'h1000;
      actual_target_address = 32'h2000;
      ex_is_branch = 1'b1;
    end
    n = 0;
    sweep_hit = 1'b0;
    while (btb_busy && n < 200) begin
      tick();
      n++;
      if (btb_hit1) sweep_hit = 1'b1;
    end
    update_btb = 1'b0;
    chk("sweep_len_reset", n, 64);
    chk("sweep_lookup_hit", 32'(sweep_hit), 0);
    tick();
    tick();
    chk("upd_dropped_in_sweep", 32'(btb_hit1), 0);

    // basic update, read-before-write, then visible
    upd(32'h1000, 32'h2000, 1'b0, 1'b1);
    look(32'h1000, 32'h1100);
    chk("rbw_hit1", 32'(btb_hit1), 0);
    look(32'h1000, 32'h1100);
    chk("upd_hit1", 32'(btb_hit1), 1);
    chk("upd_tgt1", pred_target1, 32'h2000);
    chk("upd_br1", 32'(is_branch1), 1);
    chk("upd_ret1", 32'(is_ret1), 0);
    chk("other_tag_hit2", 32'(btb_hit2), 0);
    chk("other_tag_tgt2", pred_target2, 0);

    // back-to-back fill of set 0
    upd(32'h1000, 32'h2000, 1'b0, 1'b1);
    upd(32'h1100, 32'h2100, 1'b0, 1'b1);
    upd(32'h1200, 32'h2200, 1'b0, 1'b1);
    upd(32'h1300, 32'h2300, 1'b0, 1'b1);
    tick();
    look(32'h1000, 32'h1300);
    chk("fill_hit_1000", 32'(btb_hit1), 1);
    chk("fill_hit_1300", 32'(btb_hit2), 1);
    chk("fill_tgt_1300", pred_target2, 32'h2300);
    look(32'h1100, 32'h1200);
    chk("fill_hit_1100", 32'(btb_hit1), 1);
    chk("fill_hit_1200", 32'(btb_hit2), 1);
    chk("fill_tgt_1100", pred_target1, 32'h2100);

    // round-robin eviction: way0 then way1
    upd(32'h1400, 32'h2400, 1'b0, 1'b1);
    upd(32'h1500, 32'h2500, 1'b1, 1'b0);
    tick();
    look(32'h1000, 32'h1400);
    chk("evict_1000", 32'(btb_hit1), 0);
    chk("new_hit_1400", 32'(btb_hit2), 1);
    chk("new_tgt_1400", pred_target2, 32'h2400);
    look(32'h1100, 32'h1500);
    chk("evict_1100", 32'(btb_hit1), 0);
    chk("new_hit_1500", 32'(btb_hit2), 1);
    chk("ret_1500", 32'(is_ret2), 1);
    chk("br_1500", 32'(is_branch2), 0);
    look(32'h1200, 32'h1300);
    chk("keep_1200", 32'(btb_hit1), 1);
    chk("keep_1300", 32'(btb_hit2), 1);

    // same-tag back-to-back: evicts way2 (rr=2), second must hit the same way
    upd(32'h1000, 32'h2000, 1'b0, 1'b1);
    upd(32'h1000, 32'h3000, 1'b0, 1'b1);
    tick();
    look(32'h1000, 32'h1300);
    chk("fwd_hit_1000", 32'(btb_hit1), 1);
    chk("fwd_tgt_1000", pred_target1, 32'h3000);
    chk("fwd_keep_1300", 32'(btb_hit2), 1);
    chk("fwd_tgt_1300", pred_target2, 32'h2300);
    look(32'h1200, 32'h1400);
    chk("fwd_evict_1200", 32'(btb_hit1), 0);
    chk("fwd_keep_1400", 32'(btb_hit2), 1);

    // invalidate present entry: a single invalidate must remove it entirely
    inv(32'h1000);
    tick();
    look(32'h1000, 32'h1500);
    chk("inv_miss_1000", 32'(btb_hit1), 0);
    chk("inv_keep_1500", 32'(btb_hit2), 1);

    // invalidate absent entry, then refill: 0x1600 takes freed way2, 0x1700 evicts way3 (rr=3)
    inv(32'h1700);
    upd(32'h1600, 32'h2600, 1'b0, 1'b1);
    upd(32'h1700, 32'h2700, 1'b0, 1'b1);
    tick();
    look(32'h1300, 32'h1600);
    chk("rr3_evict_1300", 32'(btb_hit1), 0);
    chk("free_hit_1600", 32'(btb_hit2), 1);
    chk("free_tgt_1600", pred_target2, 32'h2600);
    look(32'h1700, 32'h1400);
    chk("rr_hit_1700", 32'(btb_hit1), 1);
    chk("rr_tgt_1700", pred_target1, 32'h2700);
    chk("rr_keep_1400", 32'(btb_hit2), 1);
    look(32'h1500, 32'h1000);
    chk("rr_keep_1500", 32'(btb_hit1), 1);
    chk("rr_miss_1000", 32'(btb_hit2), 0);

    // flush with simultaneous update
    flush_btb = 1'b1;
    update_btb = 1'b1;
    ex_pc = 32'h1800;
    actual_target_address = 32'h2800;
    tick();
    flush_btb = 1'b0;
    update_btb = 1'b0;
    chk("flush_busy", 32'(btb_busy), 1);
    sweep_len(n);
    chk("sweep_len_flush", n, 64);
    look(32'h1400, 32'h1500);
    chk("flush_miss_1400", 32'(btb_hit1), 0);
    chk("flush_miss_1500", 32'(btb_hit2), 0);
    look(32'h1600, 32'h1700);
    chk("flush_miss_1600", 32'(btb_hit1), 0);
    chk("flush_miss_1700", 32'(btb_hit2), 0);
    look(32'h1800, 32'h1200);
    chk("flush_miss_1800", 32'(btb_hit1), 0);
    chk("flush_miss_1200", 32'(btb_hit2), 0);

    // reset mid-sweep restarts from set 0
    flush_btb = 1'b1;
    tick();
    flush_btb = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(btb_busy), 1);
    chk("midrst_hit1", 32'(btb_hit1), 0);
    tick();
    tick();
    reset_n = 1'b1;
    sweep_len(n);
    chk("sweep_len_restart", n, 64);

    // set 63 after restart
    upd(32'h10FC, 32'h2FC0, 1'b1, 1'b1);
    tick();
    look(32'h10FC, 32'h1000);
    chk("post_hit_10fc", 32'(btb_hit1), 1);
    chk("post_tgt_10fc", pred_target1, 32'h2FC0);
    chk("post_ret_10fc", 32'(is_ret1), 1);
    chk("post_miss_1000", 32'(btb_hit2), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
